// File: rtl/dmem_pkg.sv
// Shared constants for the cache-to-memory line responder: FSM encoding,
// line geometry and default sizes.
package dmem_pkg;

    localparam int LINE_OFFSET_BITS = 5;
    localparam int DEF_LINE_W       = 256;
    localparam int DEF_DEPTH        = 512;
    localparam int CTR_W            = $clog2(256);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

endpackage

// File: rtl/dmem_latency_ctr.sv
// Loadable down-counter that times the request latency; zero_o flags
// the edge on which the memory operation is performed.
import dmem_pkg::*;

module dmem_latency_ctr #(
    parameter int W = CTR_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // next count: load wins over decrement, saturating at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // counter register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == {W{1'b0}});

endmodule

// File: rtl/dmem_line_responder.sv
// Backing data memory answering the data cache's line interface: one request
// at a time, fixed programmable latency, single-cycle ack (and err when out of range).
import dmem_pkg::*;

module dmem_line_responder #(
    parameter int LINE_W  = DEF_LINE_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = 10,
    parameter int ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int IDX_W  = ADDR_W - LINE_OFFSET_BITS;
    localparam int MEM_AW = $clog2(DEPTH);

    // Not reset on purpose: contents survive reset and can be preloaded.
    logic [LINE_W-1:0] memory [DEPTH];

    logic [1:0]        state_q,  state_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic [LINE_W-1:0] wdata_q,  wdata_d;
    logic              write_q,  write_d;
    logic              ack_q,    ack_d;
    logic              err_q,    err_d;
    logic              busy_q,   busy_d;
    logic [LINE_W-1:0] rdata_q,  rdata_d;

    logic              ctr_load_s;
    logic              ctr_zero_s;
    logic              in_range_s;
    logic              fire_s;
    logic [MEM_AW-1:0] mem_idx_s;
    logic              unused_offset_s;

    assign in_range_s      = (idx_q < IDX_W'(DEPTH));
    assign mem_idx_s       = idx_q[MEM_AW-1:0];
    assign fire_s          = (state_q == ST_WAIT) && ctr_zero_s;
    assign unused_offset_s = ^addr_i[LINE_OFFSET_BITS-1:0];

    dmem_latency_ctr #(
        .W (CTR_W)
    ) u_ctr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (ctr_load_s),
        .load_val_i (CTR_W'(LATENCY - 1)),
        .dec_i      (state_q == ST_WAIT),
        .zero_o     (ctr_zero_s)
    );

    // request FSM: latch in IDLE, perform op when the counter expires, ack for one cycle
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        ctr_load_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    idx_d      = addr_i[ADDR_W-1:LINE_OFFSET_BITS];
                    wdata_d    = data_i;
                    write_d    = write_i;
                    ctr_load_s = 1'b1;
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (ctr_zero_s) begin
                    ack_d   = 1'b1;
                    err_d   = !in_range_s;
                    state_d = ST_ACK;
                    if (!write_q) begin
                        rdata_d = in_range_s ? memory[mem_idx_s] : {LINE_W{1'b0}};
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // control and output registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            wdata_q <= {LINE_W{1'b0}};
            write_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= {LINE_W{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    // line write commits on the ack-setting edge; reset clears state so an aborted write never lands
    always_ff @(posedge clk_i) begin
        if (fire_s && write_q && in_range_s) begin
            memory[mem_idx_s] <= wdata_q;
        end
    end

    assign ack_o  = ack_q;
    assign err_o  = err_q;
    assign busy_o = busy_q;
    assign data_o = rdata_q;

endmodule
